// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner.
//   scanState_t - scan FSM states (DRIVE, SAMPLE, EVAL)
//   KEY_NONE    - 5-bit frame/stable result meaning "no single key"; MSB set
//   key_map     - (row, col) -> 4-bit key code for the Pmod keypad legend
package keypad_pkg;

  typedef enum logic [1:0] {
    DRIVE  = 2'd0,
    SAMPLE = 2'd1,
    EVAL   = 2'd2
  } scanState_t;

  // Results are {none, code}; any value with the MSB set is "no key".
  localparam logic [4:0] KEY_NONE = 5'b1_0000;

  // Row 0 is the top row, col 0 is the leftmost column (col_n[0]).
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for asynchronous level inputs.
//   clk  - destination clock
//   rst  - synchronous active-high reset; both stages go to all-ones
//          (idle level of pulled-up, active-low lines)
//   d    - asynchronous input bus
//   q    - synchronized output, two clocks of latency
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      // p0: may go metastable; p1: settled copy
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: column-strobing scanner for a 4x4 keypad.
//   SETTLE_CYCLES   - cycles per column slot (>= 4); last cycle samples rows
//   DEBOUNCE_FRAMES - identical frame results needed to change output (>= 1)
//   clk, rst        - clock, synchronous active-high reset
//   row_n[3:0]      - keypad rows, active low, asynchronous
//   col_n[3:0]      - keypad columns, one-hot-low strobe
//   key_code[3:0]   - debounced key, meaningful while key_valid = 1
//   key_valid       - a single debounced key is held
//   key_press       - one-cycle pulse when a new key becomes stable
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 100000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_press
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam int DEB_W = $clog2(DEBOUNCE_FRAMES + 1);
  // DRIVE hands over to SAMPLE when the counter reaches this value, so
  // SAMPLE lands on count SETTLE_CYCLES-1, the last cycle of the slot.
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SETTLE_CYCLES - 2);
  localparam logic [DEB_W-1:0] DEB_MAX    = DEB_W'(DEBOUNCE_FRAMES);

  scanState_t       state;
  scanState_t       nextState;
  logic [CNT_W-1:0] settleCnt;
  logic [1:0]       colIdx;
  logic [15:0]      frameVec;
  logic [3:0]       rowSync;
  logic             sampleEn;
  logic             evalEn;
  logic [4:0]       frameResult;
  logic [4:0]       prevResult;
  logic [4:0]       stableState;
  logic [DEB_W-1:0] debCnt;
  logic [DEB_W-1:0] debCntNext;

  function automatic logic [DEB_W-1:0] satInc(input logic [DEB_W-1:0] v);
    return (v >= DEB_MAX) ? DEB_MAX : v + DEB_W'(1);
  endfunction

  sync2 #(.WIDTH(4)) uRowSync (
    .clk (clk),
    .rst (rst),
    .d   (row_n),
    .q   (rowSync)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= DRIVE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      DRIVE:   if (settleCnt == DRIVE_LAST) nextState = SAMPLE;
      SAMPLE:  nextState = (colIdx == 2'd3) ? EVAL : DRIVE;
      // EVAL doubles as the first settle cycle of column 0.
      EVAL:    nextState = DRIVE;
      default: nextState = DRIVE;
    endcase
  end

  always_comb begin
    col_n    = ~(4'b0001 << colIdx);
    sampleEn = (state == SAMPLE);
    evalEn   = (state == EVAL);
  end

  // ---- scan stage: column slot counter and frame capture ----
  always_ff @(posedge clk) begin
    if (rst) begin
      settleCnt <= '0;
      colIdx    <= 2'd0;
      frameVec  <= 16'h0000;
    end else begin
      settleCnt <= sampleEn ? '0 : settleCnt + CNT_W'(1);
      if (sampleEn) begin
        frameVec[{colIdx, 2'b00} +: 4] <= ~rowSync;
        colIdx <= colIdx + 2'd1;
      end
    end
  end

  // Bit index in frameVec is {col, row}. Zero or several pressed bits
  // (including ghost patterns) all collapse to KEY_NONE.
  always_comb begin
    frameResult = KEY_NONE;
    if ($countones(frameVec) == 1) begin
      for (int i = 0; i < 16; i++) begin
        if (frameVec[i]) frameResult = {1'b0, key_map(i[1:0], i[3:2])};
      end
    end
    debCntNext = (frameResult == prevResult) ? satInc(debCnt) : DEB_W'(1);
  end

  // ---- debounce stage: runs once per frame in EVAL ----
  always_ff @(posedge clk) begin
    if (rst) begin
      prevResult  <= KEY_NONE;
      stableState <= KEY_NONE;
      debCnt      <= '0;
      key_valid   <= 1'b0;
      key_code    <= 4'h0;
      key_press   <= 1'b0;
    end else begin
      key_press <= 1'b0;
      if (evalEn) begin
        prevResult <= frameResult;
        debCnt     <= debCntNext;
        if ((debCntNext == DEB_MAX) && (frameResult != stableState)) begin
          stableState <= frameResult;
          key_valid   <= ~frameResult[4];
          // key_code keeps the last key when the stable state drops to none.
          if (!frameResult[4]) begin
            key_code  <= frameResult[3:0];
            key_press <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with SETTLE_CYCLES=8,
// DEBOUNCE_FRAMES=3 (32-cycle frames). The keypad model pulls a row low
// only while a pressed key's column is driven low.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_press;

  logic [15:0] keys = 16'h0000;   // bit c*4+r = key at row r, col c held

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          pressCount = 0;
  int          lastPressCyc = -1;
  logic [3:0]  lastPressCode = 4'h0;

  keypad_scan #(
    .SETTLE_CYCLES   (8),
    .DEBOUNCE_FRAMES (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_press (key_press)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && (col_n[c] == 1'b0)) row_n[r] = 1'b0;
  end

  // Advance one cycle; sample 1 time unit after the edge and log pulses.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (key_press === 1'b1) begin
      pressCount++;
      lastPressCyc  = cyc;
      lastPressCode = key_code;
    end
  endtask

  // Leaves the bench in cycle 0 after reset release.
  task automatic doReset(input logic [15:0] held);
    keys = held;
    rst  = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    cyc = 0;
    pressCount = 0;
    lastPressCyc = -1;
  endtask

  task automatic test_reset();
    doReset(16'h0000);
    checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL reset_col_n got=%b exp=1110", col_n); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_key_valid got=%b exp=0", key_valid); end
    checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL reset_key_code got=%h exp=0", key_code); end
    checks++; if (key_press !== 1'b0) begin failures++; $display("FAIL reset_key_press got=%b exp=0", key_press); end
  endtask

  // Continues from test_reset: no key, three frames.
  task automatic test_scan();
    logic [3:0] expCol;
    bit         sawValid;
    sawValid = 0;
    while (cyc < 96) begin
      if ((cyc % 8 == 0) || (cyc % 8 == 7)) begin
        expCol = 4'b1111;
        expCol[(cyc / 8) % 4] = 1'b0;
        checks++;
        if (col_n !== expCol) begin
          failures++;
          $display("FAIL scan_col_n cycle=%0d got=%b exp=%b", cyc, col_n, expCol);
        end
      end
      if (key_valid !== 1'b0) sawValid = 1;
      step();
    end
    checks++; if (sawValid) begin failures++; $display("FAIL idle_key_valid got=1 exp=0"); end
    checks++; if (pressCount != 0) begin failures++; $display("FAIL idle_press_count got=%0d exp=0", pressCount); end
  endtask

  task automatic test_press5();
    bit dropped;
    dropped = 0;
    doReset(16'h0020);
    while (cyc < 96) step();
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL press5_valid_early got=%b exp=0", key_valid); end
    step();
    checks++; if (key_press !== 1'b1) begin failures++; $display("FAIL press5_pulse_c97 got=%b exp=1", key_press); end
    checks++; if (key_code !== 4'h5) begin failures++; $display("FAIL press5_code got=%h exp=5", key_code); end
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL press5_valid got=%b exp=1", key_valid); end
    while (cyc < 150) begin
      step();
      if (key_valid !== 1'b1) dropped = 1;
    end
    checks++; if (dropped) begin failures++; $display("FAIL press5_valid_held got=0 exp=1"); end
    checks++; if (pressCount != 1) begin failures++; $display("FAIL press5_count got=%0d exp=1", pressCount); end
    checks++; if (lastPressCyc != 97) begin failures++; $display("FAIL press5_cycle got=%0d exp=97", lastPressCyc); end
  endtask

  // Continues from test_press5 with "5" still held.
  task automatic test_release();
    int startCyc;
    int p0;
    startCyc = cyc;
    p0 = pressCount;
    keys = 16'h0000;
    while ((key_valid === 1'b1) && (cyc - startCyc < 129)) step();
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL release_valid_fall got=%b exp=0 after %0d cycles", key_valid, cyc - startCyc);
    end
    checks++; if (pressCount != p0) begin failures++; $display("FAIL release_pulse got=%0d exp=%0d", pressCount, p0); end
  endtask

  task automatic test_two_keys();
    bit sawValid;
    sawValid = 0;
    doReset(16'h0420);   // "5" (r1,c1) and "9" (r2,c2)
    while (cyc < 130) begin
      step();
      if (key_valid !== 1'b0) sawValid = 1;
    end
    checks++; if (sawValid) begin failures++; $display("FAIL multi_key_valid got=1 exp=0"); end
    checks++; if (pressCount != 0) begin failures++; $display("FAIL multi_key_press got=%0d exp=0", pressCount); end
  endtask

  task automatic test_bounce();
    doReset(16'h8000);   // "D" (r3,c3)
    while (cyc < 200) begin
      if (cyc < 64) keys = (((cyc / 20) % 2) == 0) ? 16'h8000 : 16'h0000;
      else          keys = 16'h8000;
      if (cyc == 160) begin
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL bounce_valid_early got=%b exp=0", key_valid); end
      end
      step();
    end
    checks++; if (pressCount != 1) begin failures++; $display("FAIL bounce_count got=%0d exp=1", pressCount); end
    checks++; if (lastPressCyc != 161) begin failures++; $display("FAIL bounce_cycle got=%0d exp=161", lastPressCyc); end
    checks++; if (lastPressCode !== 4'hD) begin failures++; $display("FAIL bounce_code got=%h exp=d", lastPressCode); end
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL bounce_valid got=%b exp=1", key_valid); end
  endtask

  task automatic test_reset_mid();
    doReset(16'h1000);   // "A" (r0,c3)
    while (cyc < 112) step();
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL rmid_valid_pre got=%b exp=1", key_valid); end
    checks++; if (key_code !== 4'hA) begin failures++; $display("FAIL rmid_code_pre got=%h exp=a", key_code); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    pressCount = 0;
    lastPressCyc = -1;
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", key_valid); end
    checks++; if (key_code !== 4'h0) begin failures++; $display("FAIL rmid_code got=%h exp=0", key_code); end
    checks++; if (key_press !== 1'b0) begin failures++; $display("FAIL rmid_press got=%b exp=0", key_press); end
    checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL rmid_col_n got=%b exp=1110", col_n); end
    while (cyc < 130) step();
    checks++; if (pressCount != 1) begin failures++; $display("FAIL rmid_count got=%0d exp=1", pressCount); end
    checks++; if (lastPressCyc != 97) begin failures++; $display("FAIL rmid_cycle got=%0d exp=97", lastPressCyc); end
    checks++; if (lastPressCode !== 4'hA) begin failures++; $display("FAIL rmid_code_new got=%h exp=a", lastPressCode); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_press5();
    test_release();
    test_two_keys();
    test_bounce();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
